remote_comm: RTL and testbench
==============================

// Module: remote_comm
// PURPOSE
//  Bench/host-side UART command link for the Knight robot. Splits a 16-bit command into two
//  UART bytes (high byte first) on TX and reports the 8-bit response byte received on RX.
//  Sits opposite the robot's UART_wrapper; drives the wrapper's RX and receives its TX.
// PARAMETERS
//  BAUD_CYCLES     434     clocks per UART bit (115200 baud at 50 MHz); min 16
//  TIMEOUT_CYCLES  2000000 response timeout in clocks (used only with RC_TIMEOUT_EN)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  RX            in   1   serial in from robot (async; double-flop sync, flops preset to 1)
//  TX            out  1   serial out to robot, idle high
//  cmd           in   16  command word, sampled on the cycle send_cmd=1 in IDLE
//  send_cmd      in   1   one-cycle request to transmit cmd
//  cmd_sent      out  1   high once both bytes are fully sent; stays high until next accepted send_cmd
//  resp_rdy      out  1   high while resp holds a new, unconsumed response byte
//  resp          out  8   last received response byte (e.g. 8'hA5 = ack)
// BEHAVIOUR
//  Reset: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, FSM=IDLE, RX sync flops=1.
//  UART frame: 1 start(0), 8 data LSB first, 1 stop(1); each bit lasts BAUD_CYCLES clocks.
//  TX FSM: IDLE -> TX_HI -> TX_LO -> DONE(=IDLE with cmd_sent=1).
//   - IDLE: send_cmd=1 latches cmd into cmd_q, clears cmd_sent and resp_rdy, starts byte cmd_q[15:8].
//   - TX_HI: wait tx_done, then start byte cmd_q[7:0] on the next cycle (no idle gap > 1 clk).
//   - TX_LO: on tx_done set cmd_sent=1, return to IDLE.
//   - Start bit begins the cycle after send_cmd; cmd_sent rises 20*BAUD_CYCLES+2 clocks (±2) after.
//   - send_cmd while not IDLE is ignored; cmd changes after acceptance do not affect the frame.
//  RX: falling edge of synced RX while receiver idle starts a frame; sample at mid-bit
//   (BAUD_CYCLES/2 after edge, then every BAUD_CYCLES). After the stop-bit sample, resp<=byte
//   and resp_rdy=1 (stop value not checked; no framing error output).
//   - resp_rdy clears on an accepted send_cmd or on the start edge of the next incoming byte.
//   - resp holds its value until the next complete byte overwrites it.
//   - RX receive is independent of TX activity (full duplex).
//  Simultaneous: byte completes same cycle as accepted send_cmd -> resp updated, resp_rdy=1 wins.
//  Reset mid-operation: frames abort immediately, TX forced high, all outputs to reset values.
// CONFIGURATION
//  RC_TIMEOUT_EN defined: adds output resp_timeout (1 bit). Counter starts when cmd_sent rises,
//   stops/clears on resp_rdy rise or accepted send_cmd; at TIMEOUT_CYCLES resp_timeout pulses 1 clk.
//  Not defined: no port, no counter; otherwise identical behaviour.
// STRUCTURE
//  Package remote_comm_pkg: typedef enum tx_state_t {IDLE,TX_HI,TX_LO}; rx state enum;
//   localparams FRAME_BITS=10, default BAUD_CYCLES.
//  Sub-module uart_xcvr (trmt/tx_data/tx_done, rx_rdy/rx_data/clr_rx_rdy, TX/RX, BAUD_CYCLES param);
//   remote_comm holds only the byte-sequencing FSM, cmd latch, cmd_sent and timeout logic.
// TESTING
//  1 cmd=16'h2001, send_cmd pulse -> TX serialises 0x20 then 0x01 (bits LSB first), cmd_sent=1
//    after ~20*BAUD_CYCLES, cmd_sent=0 before that.
//  2 Loop TX to an independent UART that returns 8'hA5 -> resp=8'hA5, resp_rdy=1; next send_cmd
//    clears resp_rdy the following cycle.
//  3 send_cmd asserted again mid-transfer with cmd=16'hFFFF -> ignored, wire still shows 0x20,0x01.
//  4 Back-to-back: second send_cmd (16'h2001) right after cmd_sent -> cmd_sent drops, new frame pair.
//  5 rst_n low mid high-byte -> TX=1 same cycle, cmd_sent=0, resp_rdy=0; recovers on next send_cmd.
//  6 RC_TIMEOUT_EN, TIMEOUT_CYCLES=5000, no response -> resp_timeout pulses once 5000 clks after cmd_sent.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm host-side UART command link.
package remote_comm_pkg;
  localparam int FRAME_BITS          = 10;
  localparam int DEFAULT_BAUD_CYCLES = 434;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_BUSY}   rx_state_t;
endpackage

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART transceiver: frames one byte per trmt strobe, reports received bytes.
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);
  localparam int             CW        = $clog2(BAUD_CYCLES);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic          tx_busy;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !tx_busy) begin
        TX       <= 1'b0;
        tx_shift <= {1'b1, tx_data};
        tx_baud  <= '0;
        tx_bit   <= '0;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud <= '0;
          if (tx_bit == LAST_BIT) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            TX       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
          end
        end else begin
          tx_baud <= tx_baud + 1'b1;
        end
      end
    end
  end

  // Line idles high, so the synchroniser presets to 1 to avoid a false start edge.
  logic rx_ff1, rx_ff2, rx_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  rx_state_t     rx_state;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_fall;

  assign rx_fall = rx_prev & ~rx_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_state <= RX_BUSY;
          rx_baud  <= HALF_LAST;
          rx_bit   <= '0;
          rx_rdy   <= 1'b0;
        end
        RX_BUSY: if (rx_baud == '0) begin
          rx_baud <= BAUD_LAST;
          rx_bit  <= rx_bit + 1'b1;
          // Completion is placed last so it overrides a same-cycle clear.
          if (rx_bit == LAST_BIT) begin
            rx_data  <= rx_shift;
            rx_rdy   <= 1'b1;
            rx_state <= RX_IDLE;
          end else if (rx_bit != 4'd0) begin
            rx_shift <= {rx_ff2, rx_shift[7:1]};
          end
        end else begin
          rx_baud <= rx_baud - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/remote_comm.sv
// Host-side command link: sends a 16-bit command as two UART bytes, reports the response byte.
// Optional RC_TIMEOUT_EN adds resp_timeout, a 1-clk pulse when no response arrives in time.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
`ifdef RC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
`ifdef RC_TIMEOUT_EN
  , output logic      resp_timeout
`endif
);
  tx_state_t   state;
  logic [15:0] cmd_q;
  logic        accept, trmt, tx_done;
  logic [7:0]  tx_data;

  assign accept = (state == IDLE) && send_cmd;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    trmt    = 1'b0;
    tx_data = cmd[15:8];
    if (accept) begin
      trmt = 1'b1;
    end else if (state == TX_HI && tx_done) begin
      trmt    = 1'b1;
      tx_data = cmd_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      cmd_sent <= 1'b0;
    end else begin
      case (state)
        IDLE: if (send_cmd) begin
          cmd_q    <= cmd;
          cmd_sent <= 1'b0;
          state    <= TX_HI;
        end
        TX_HI: if (tx_done) state <= TX_LO;
        TX_LO: if (tx_done) begin
          cmd_sent <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_xcvr #(.BAUD_CYCLES(BAUD_CYCLES)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .TX         (TX),
    .RX         (RX),
    .clr_rx_rdy (accept),
    .rx_rdy     (resp_rdy),
    .rx_data    (resp)
  );

`ifdef RC_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_run, resp_rdy_q, cmd_done;

  assign cmd_done = (state == TX_LO) && tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      to_run       <= 1'b0;
      resp_rdy_q   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_rdy_q   <= resp_rdy;
      resp_timeout <= 1'b0;
      if (accept || (resp_rdy && !resp_rdy_q)) begin
        to_run <= 1'b0;
        to_cnt <= '0;
      end else if (cmd_done) begin
        to_run <= 1'b1;
        to_cnt <= '0;
      end else if (to_run) begin
        if (to_cnt == TO_LAST) begin
          resp_timeout <= 1'b1;
          to_run       <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_remote_comm.sv
// Directed self-checking bench for remote_comm: framing, response, ignore, back-to-back, reset.
module tb_remote_comm;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line = 1'b1;
  logic        send_cmd = 1'b0;
  logic [15:0] cmd = '0;
  wire         tx_line, cmd_sent, resp_rdy;
  wire  [7:0]  resp;
`ifdef RC_TIMEOUT_EN
  wire         resp_timeout;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0, tc, lows;
  logic [7:0] b_hi, b_lo;

  remote_comm #(
    .BAUD_CYCLES(B)
`ifdef RC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(5000)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (rx_line),
    .TX       (tx_line),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
`ifdef RC_TIMEOUT_EN
    , .resp_timeout (resp_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; send_cmd is seen by exactly one rising edge.
  task automatic pulse_send(input logic [15:0] c, output int t);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    t = cyc;
  endtask

  task automatic capture_byte(input string tag, output logic [7:0] b);
    int n = 0;
    while (tx_line !== 1'b0 && n < 40 * B) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, tx_line, 1'b0);
    wait_cycles(B / 2);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(B);
      b[i] = tx_line;
    end
    wait_cycles(B);
    check({tag, "_stop"}, tx_line, 1'b1);
  endtask

  task automatic wait_sent(input int t, input string tag);
    int n = 0;
    while (cmd_sent !== 1'b1 && n < 30 * B) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sent"}, cmd_sent, 1'b1);
    check({tag, "_latency_ok"}, (cyc - t >= 20 * B) && (cyc - t <= 20 * B + 4), 1'b1);
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    rx_line = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      wait_cycles(B);
    end
    rx_line = 1'b1;
    wait_cycles(B);
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (resp_rdy !== 1'b1 && n < 15 * B) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, resp_rdy, 1'b1);
  endtask

  initial begin
    wait_cycles(3);
    check("rst_tx", tx_line, 1'b1);
    check("rst_cmd_sent", cmd_sent, 1'b0);
    check("rst_resp_rdy", resp_rdy, 1'b0);
    check("rst_resp", resp, 8'h00);
    rst_n = 1'b1;
    wait_cycles(2);

    // Basic command: 0x2001 goes out as 0x20 then 0x01.
    pulse_send(16'h2001, t0);
    capture_byte("t1_hi", b_hi);
    check("t1_hi_byte", b_hi, 8'h20);
    check("t1_cmd_sent_mid", cmd_sent, 1'b0);
    capture_byte("t1_lo", b_lo);
    check("t1_lo_byte", b_lo, 8'h01);
    wait_sent(t0, "t1");

    // Response byte from the robot side.
    send_rx_byte(8'hA5);
    wait_resp("t2");
    check("t2_resp", resp, 8'hA5);

    // Next command clears resp_rdy; a mid-frame request with 0xFFFF is ignored.
    pulse_send(16'h2001, t0);
    check("t2_rdy_cleared", resp_rdy, 1'b0);
    check("t3_cmd_sent_clr", cmd_sent, 1'b0);
    check("t3_resp_held", resp, 8'hA5);
    fork
      begin
        capture_byte("t3_hi", b_hi);
        capture_byte("t3_lo", b_lo);
      end
      begin
        wait_cycles(5 * B);
        cmd = 16'hFFFF;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
      end
    join
    check("t3_hi_byte", b_hi, 8'h20);
    check("t3_lo_byte", b_lo, 8'h01);
    wait_sent(t0, "t3");

    // Back-to-back command with a concurrent incoming byte.
    pulse_send(16'h2001, t0);
    check("t4_cmd_sent_drop", cmd_sent, 1'b0);
    fork
      begin
        capture_byte("t4_hi", b_hi);
        capture_byte("t4_lo", b_lo);
      end
      begin
        wait_cycles(3 * B);
        send_rx_byte(8'h3C);
      end
    join
    check("t4_hi_byte", b_hi, 8'h20);
    check("t4_lo_byte", b_lo, 8'h01);
    wait_sent(t0, "t4");
    check("t4_resp", resp, 8'h3C);
    check("t4_resp_rdy", resp_rdy, 1'b1);
    lows = 0;
    for (int i = 0; i < 3 * B; i++) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
    end
    check("t4_tx_idle_after", lows, 0);

    // Start edge of a new incoming byte clears resp_rdy; resp holds until overwritten.
    fork
      send_rx_byte(8'h5A);
      begin
        wait_cycles(2 * B);
        check("t4b_rdy_clr_on_start", resp_rdy, 1'b0);
        check("t4b_resp_held", resp, 8'h3C);
      end
    join
    wait_resp("t4b");
    check("t4b_resp", resp, 8'h5A);

    // Reset in the middle of the high byte.
    pulse_send(16'h2001, t0);
    wait_cycles(3 * B + B / 2);
    check("t5_tx_low_before_rst", tx_line, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_tx_rst", tx_line, 1'b1);
    check("t5_cmd_sent_rst", cmd_sent, 1'b0);
    check("t5_resp_rdy_rst", resp_rdy, 1'b0);
    check("t5_resp_rst", resp, 8'h00);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    check("t5_tx_idle", tx_line, 1'b1);
    pulse_send(16'h2001, t0);
    capture_byte("t5_hi", b_hi);
    capture_byte("t5_lo", b_lo);
    check("t5_hi_byte", b_hi, 8'h20);
    check("t5_lo_byte", b_lo, 8'h01);
    wait_sent(t0, "t5");

`ifdef RC_TIMEOUT_EN
    // No response follows, so resp_timeout pulses 5000 clocks after cmd_sent.
    tc = cyc;
    begin
      int n = 0;
      while (resp_timeout !== 1'b1 && n < 6000) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_timeout_seen", resp_timeout, 1'b1);
    check("t6_timeout_delay", cyc - tc, 5000);
    @(negedge clk);
    check("t6_timeout_pulse", resp_timeout, 1'b0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_timeout === 1'b1) lows++;
    end
    check("t6_single_pulse", lows, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
